// File: rtl/vga_pkg.sv
// vga_pkg
// Shared types and constants for the VGA test-pattern generator.
//   mode_e        : selectable test patterns
//   DEF_H_PIXELS  : default visible columns
//   DEF_V_PIXELS  : default visible rows
//   NUM_BARS      : number of vertical colour bars in the bar pattern
//   bar_code()    : 3-bit {r,g,b} on/off code for a bar index
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  localparam int DEF_H_PIXELS = 200;
  localparam int DEF_V_PIXELS = 100;
  localparam int NUM_BARS     = 8;

  // Bar 0 is white (code 7) and the last bar is black (code 0).
  function automatic logic [2:0] bar_code(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction

endpackage

// File: rtl/vga_bar_counter.sv
// vga_bar_counter
// Tracks which colour bar the current pixel belongs to without a divider.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   active_i   : current pixel is in the visible area
//   col_zero_i : current pixel is column 0 (restarts the count)
//   bar_idx_o  : bar index of the current pixel, 0..7, saturating at 7
module vga_bar_counter
  import vga_pkg::*;
#(
  parameter int H_BITS = 9,
  parameter int BAR_W  = DEF_H_PIXELS / NUM_BARS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active_i,
  input  logic       col_zero_i,
  output logic [2:0] bar_idx_o
);

  localparam logic [H_BITS-1:0] CNT_LAST = H_BITS'(BAR_W - 1);

  logic [H_BITS-1:0] cnt_q, cnt_d, cnt_cur;
  logic [2:0]        idx_q, idx_d, idx_cur;

  // The registers hold the position of the pixel that follows the last
  // active one. Column 0 overrides them combinationally so the first pixel
  // of a line is always in bar 0 regardless of what the previous line left.
  always_comb begin
    cnt_cur = col_zero_i ? '0   : cnt_q;
    idx_cur = col_zero_i ? 3'd0 : idx_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (active_i) begin
      if (cnt_cur == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_cur == 3'd7) ? 3'd7 : idx_cur + 3'd1;
      end else begin
        cnt_d = cnt_cur + H_BITS'(1);
        idx_d = idx_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign bar_idx_o = idx_cur;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Test-pattern generator sitting behind a VGA timing generator. One cycle
// after each (disp_ena, col, row) it presents the pixel colour for the
// active pattern. Pattern changes are deferred to the next frame start.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   disp_ena, col, row   : visible-area strobe and pixel coordinates
//   mode_req, mode_valid : requested pattern and its request strobe
//   solid_rgb            : {r,g,b} for the solid pattern
//   mode_ack             : pulses with the first pixel drawn in a new mode
//   r, g, b, pix_valid   : pixel colour and the delayed disp_ena
// Build option: define VGA_PAT_BORDER_EN to force a one-pixel white border.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_BITS     = 9,
  parameter int V_BITS     = 7,
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int V_PIXELS   = DEF_V_PIXELS,
  parameter int COLOR_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_ena,
  input  logic [H_BITS-1:0]       col,
  input  logic [V_BITS-1:0]       row,
  input  logic [1:0]              mode_req,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  input  logic                    mode_valid,
  output logic                    mode_ack,
  output logic [COLOR_BITS-1:0]   r,
  output logic [COLOR_BITS-1:0]   g,
  output logic [COLOR_BITS-1:0]   b,
  output logic                    pix_valid
);

  localparam logic [COLOR_BITS-1:0] ONES = '1;

  mode_e                 mode_q, mode_d;
  mode_e                 pend_mode_q, pend_mode_d;
  logic                  pend_q, pend_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  ack_d;
  logic                  frame_start;
  logic [2:0]            bar_idx;
  logic [2:0]            bar_rgb;
  logic [COLOR_BITS-1:0] r_d, g_d, b_d;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q;
  logic                  pix_valid_q, mode_ack_q;

  assign frame_start = disp_ena && (col == '0) && (row == '0);

  vga_bar_counter #(
    .H_BITS (H_BITS),
    .BAR_W  (H_PIXELS / NUM_BARS)
  ) u_bar_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .active_i   (disp_ena),
    .col_zero_i (col == '0),
    .bar_idx_o  (bar_idx)
  );

  assign bar_rgb = bar_code(bar_idx);

`ifdef VGA_PAT_BORDER_EN
  localparam logic [H_BITS-1:0] COL_LAST = H_BITS'(H_PIXELS - 1);
  localparam logic [V_BITS-1:0] ROW_LAST = V_BITS'(V_PIXELS - 1);
  logic on_border;
  assign on_border = (col == '0) || (col == COL_LAST) ||
                     (row == '0) || (row == ROW_LAST);
`else
  // V_PIXELS only shapes the border; without it the constant is tied off.
  logic unused_vpix;
  assign unused_vpix = ^V_BITS'(V_PIXELS - 1);
`endif

  // Mode bookkeeping. The mode, frame counter and ack are resolved
  // combinationally so that the frame-start pixel itself is drawn with the
  // freshly applied mode and the freshly incremented frame count. A request
  // arriving on the frame-start pixel wins over any older pending one.
  always_comb begin
    mode_d      = mode_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    frame_cnt_d = frame_cnt_q;
    ack_d       = 1'b0;
    if (frame_start) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (mode_valid) begin
        mode_d = mode_e'(mode_req);
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end else if (pend_q) begin
        mode_d = pend_mode_q;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
    end else if (mode_valid) begin
      pend_d      = 1'b1;
      pend_mode_d = mode_e'(mode_req);
    end
  end

  // Pixel colour for the current coordinates; blanked pixels stay black.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (disp_ena) begin
      case (mode_d)
        MODE_SOLID: {r_d, g_d, b_d} = solid_rgb;
        MODE_BARS: begin
          r_d = {COLOR_BITS{bar_rgb[2]}};
          g_d = {COLOR_BITS{bar_rgb[1]}};
          b_d = {COLOR_BITS{bar_rgb[0]}};
        end
        MODE_CHECK: begin
          if (col[3] ^ row[3]) begin
            r_d = ONES;
            g_d = ONES;
            b_d = ONES;
          end
        end
        MODE_GRAD: begin
          r_d = col[H_BITS-1 -: COLOR_BITS] + frame_cnt_d[COLOR_BITS-1:0];
          g_d = row[V_BITS-1 -: COLOR_BITS];
          b_d = frame_cnt_d[7 -: COLOR_BITS];
        end
        default: ;
      endcase
`ifdef VGA_PAT_BORDER_EN
      if (on_border) begin
        r_d = ONES;
        g_d = ONES;
        b_d = ONES;
      end
`endif
    end
  end

  // All state and the registered pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_SOLID;
      pend_q      <= 1'b0;
      pend_mode_q <= MODE_SOLID;
      frame_cnt_q <= 8'd0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      pix_valid_q <= 1'b0;
      mode_ack_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      frame_cnt_q <= frame_cnt_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      pix_valid_q <= disp_ena;
      mode_ack_q  <= ack_d;
    end
  end

  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign pix_valid = pix_valid_q;
  assign mode_ack  = mode_ack_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
// Scoreboard bench for vga_pattern_gen: the stimulus side predicts each
// pixel from an arithmetic model of the pattern rules and queues it; a
// negedge monitor pops one entry per presented output and compares.
// Honours VGA_PAT_BORDER_EN the same way the design does.
module tb_vga_pattern_gen;

  localparam int HPIX  = 200;
  localparam int VPIX  = 100;
  localparam int BAR_W = HPIX / 8;

  typedef struct {
    logic       valid;
    logic       ack;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    int         col;
    int         row;
    string      tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        disp_ena;
  logic [8:0]  col;
  logic [6:0]  row;
  logic [1:0]  mode_req;
  logic [11:0] solid_rgb;
  logic        mode_valid;
  logic        mode_ack;
  logic [3:0]  r, g, b;
  logic        pix_valid;

  exp_t expQ[$];
  int   checks;
  int   errors;

  // Reference model state
  int mMode, mPend, mPendMode, mFc;

  vga_pattern_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_ena   (disp_ena),
    .col        (col),
    .row        (row),
    .mode_req   (mode_req),
    .solid_rgb  (solid_rgb),
    .mode_valid (mode_valid),
    .mode_ack   (mode_ack),
    .r          (r),
    .g          (g),
    .b          (b),
    .pix_valid  (pix_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    mMode     = 0;
    mPend     = 0;
    mPendMode = 0;
    mFc       = 0;
  endfunction

  // Pattern rules expressed with plain integer arithmetic.
  function automatic exp_t modelStep(input logic de, input int c, input int rw,
                                     input logic mv, input int req,
                                     input logic [11:0] solid);
    exp_t e;
    bit   fs;
    int   k, code;
    fs    = de && (c == 0) && (rw == 0);
    e.ack = 1'b0;
    if (fs) begin
      mFc = (mFc + 1) % 256;
      if (mv) begin
        mMode = req; mPend = 0; e.ack = 1'b1;
      end else if (mPend != 0) begin
        mMode = mPendMode; mPend = 0; e.ack = 1'b1;
      end
    end else if (mv) begin
      mPend = 1; mPendMode = req;
    end
    e.valid = de;
    e.r = 4'd0; e.g = 4'd0; e.b = 4'd0;
    if (de) begin
      case (mMode)
        0: {e.r, e.g, e.b} = solid;
        1: begin
          k = c / BAR_W;
          if (k > 7) k = 7;
          code = 7 - k;
          e.r = (code >= 4)          ? 4'hF : 4'h0;
          e.g = (((code / 2) % 2) != 0) ? 4'hF : 4'h0;
          e.b = ((code % 2) != 0)    ? 4'hF : 4'h0;
        end
        2: begin
          if (((c / 8) % 2) != ((rw / 8) % 2)) begin
            e.r = 4'hF; e.g = 4'hF; e.b = 4'hF;
          end
        end
        default: begin
          e.r = 4'(((c / 32) + mFc) % 16);
          e.g = 4'((rw / 8) % 16);
          e.b = 4'((mFc / 16) % 16);
        end
      endcase
`ifdef VGA_PAT_BORDER_EN
      if (c == 0 || c == HPIX - 1 || rw == 0 || rw == VPIX - 1) begin
        e.r = 4'hF; e.g = 4'hF; e.b = 4'hF;
      end
`endif
    end
    return e;
  endfunction

  // Drives one pixel, predicts it, and queues the prediction once the DUT
  // has sampled it. Entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input logic de, input int c, input int rw,
                               input logic mv, input int req,
                               input logic [11:0] solid, input string tag);
    exp_t e;
    disp_ena   = de;
    col        = 9'(c);
    row        = 7'(rw);
    mode_valid = mv;
    mode_req   = 2'(req);
    solid_rgb  = solid;
    e     = modelStep(de, c, rw, mv, req, solid);
    e.col = c;
    e.row = rw;
    e.tag = tag;
    @(posedge clk);
    #1;
    expQ.push_back(e);
    mode_valid = 1'b0;
  endtask

  task automatic driveLine(input int rw, input int ncols, input int nblank,
                           input int mvCol, input int req,
                           input bit randSolid, input logic [11:0] fixedSolid,
                           input string tag);
    for (int c = 0; c < ncols; c++)
      applyStimulus(1'b1, c, rw, (c == mvCol), req,
                    randSolid ? 12'($urandom) : fixedSolid, tag);
    for (int i = 0; i < nblank; i++)
      applyStimulus(1'b0, ncols, rw, 1'b0, 0, fixedSolid, tag);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [14:0] got, want;
    got  = {pix_valid, mode_ack, r, g, b};
    want = {e.valid, e.ack, e.r, e.g, e.b};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s col=%0d row=%0d got v=%b ack=%b rgb=%h%h%h expected v=%b ack=%b rgb=%h%h%h",
               e.tag, e.col, e.row, pix_valid, mode_ack, r, g, b,
               e.valid, e.ack, e.r, e.g, e.b);
    end
  endtask

  task automatic checkReset(input string tag);
    checks++;
    if ({pix_valid, mode_ack, r, g, b} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL %s got v=%b ack=%b rgb=%h%h%h expected all zero",
               tag, pix_valid, mode_ack, r, g, b);
    end
  endtask

  // Asserts reset mid-cycle once the scoreboard is drained, leaving the
  // current inputs applied so the immediate clear is observable.
  task automatic applyReset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkReset({tag, "_immediate"});
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkReset({tag, "_held"});
    disp_ena   = 1'b0;
    mode_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: one queued prediction per output cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired, got no finish expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    disp_ena   = 1'b0;
    col        = '0;
    row        = '0;
    mode_req   = '0;
    mode_valid = 1'b0;
    solid_rgb  = '0;
    modelReset();

    $display("[TB] reset and solid pattern");
    applyReset("reset");
    for (int rw = 0; rw < VPIX; rw++)
      driveLine(rw, HPIX, 4, -1, 0, 1'b0, 12'hA5C, "solid");

    $display("[TB] colour bars applied at frame start");
    driveLine(0, HPIX, 4, 0, 1, 1'b0, 12'h000, "bars");

    $display("[TB] mid-frame checkerboard request, border pixel");
    driveLine(1, HPIX, 4, 10, 2, 1'b0, 12'h000, "bars_pending");
    driveLine(2, HPIX, 4, -1, 0, 1'b0, 12'h000, "bars_pending");
    driveLine(0, HPIX, 4, -1, 0, 1'b0, 12'h000, "check");
    driveLine(8, HPIX, 4, -1, 0, 1'b0, 12'h000, "check");
    driveLine(40, HPIX, 4, -1, 0, 1'b0, 12'h000, "check_border");
    driveLine(VPIX - 1, HPIX, 4, -1, 0, 1'b0, 12'h000, "check_border");

    $display("[TB] gradient over 17 frames");
    applyReset("reset_grad");
    for (int f = 0; f < 17; f++) begin
      driveLine(0, 40, 4, (f == 0) ? 0 : -1, 3, 1'b0, 12'h000, "grad");
      driveLine(8, 40, 4, -1, 0, 1'b0, 12'h000, "grad");
    end

    $display("[TB] reset mid-frame with a pending request");
    driveLine(0, HPIX, 4, -1, 0, 1'b0, 12'h000, "grad_pre_reset");
    driveLine(10, HPIX, 4, 50, 1, 1'b0, 12'h000, "grad_pending");
    driveLine(50, 100, 0, -1, 0, 1'b0, 12'h000, "grad_pending");
    col = 9'd100;
    applyReset("reset_midframe");
    driveLine(51, HPIX, 4, -1, 0, 1'b1, 12'h000, "after_reset");
    driveLine(0, HPIX, 4, -1, 0, 1'b1, 12'h000, "after_reset_frame");

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      int rw;
      rw = 0;
      while (rw < VPIX) begin
        int len;
        len = $urandom_range(1, HPIX);
        for (int c = 0; c < len; c++)
          applyStimulus(1'b1, c, rw, ($urandom_range(0, 40) == 0),
                        $urandom_range(0, 3), 12'($urandom), "random");
        for (int i = 0, n = $urandom_range(1, 5); i < n; i++)
          applyStimulus(1'b0, $urandom_range(0, HPIX - 1), rw,
                        ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                        12'($urandom), "random_blank");
        rw = (rw == VPIX - 1) ? VPIX : rw + $urandom_range(1, 40);
        if (rw > VPIX - 1 && rw < VPIX + 40 && rw != VPIX) rw = VPIX - 1;
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d queued expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
